// File: rtl/dehaze_pkg.sv
// -----------------------------------------------------------------------------
// dehaze_pkg
// Shared types and constants for the dehaze atmospheric-light controller.
//   - state_e        : frame controller states
//   - PIX_W          : pixel / transmission width
//   - *_DEF          : default parameter values for the controller
//   - min_u8         : unsigned 8-bit minimum
//   - atmos_iir_step : 3/4 old + 1/4 new smoothing with rounding
// -----------------------------------------------------------------------------
package dehaze_pkg;

    localparam int PIX_W = 8;

    localparam logic [10:0]      IMG_HDISP_DEF     = 11'd1024;
    localparam logic [10:0]      IMG_VDISP_DEF     = 11'd768;
    localparam logic [PIX_W-1:0] T_MIN_DEF         = 8'd26;
    localparam logic [PIX_W-1:0] ATMOS_DEFAULT_DEF = 8'd220;
    localparam logic [PIX_W-1:0] ATMOS_MAX_DEF     = 8'd240;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2,
        COMMIT = 2'd3
    } state_e;

    function automatic logic [PIX_W-1:0] min_u8(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // 10-bit accumulator: worst case 3*255 + 255 + 2 = 1022 never overflows.
    function automatic logic [PIX_W-1:0] atmos_iir_step(input logic [PIX_W-1:0] prev,
                                                        input logic [PIX_W-1:0] meas);
        logic [9:0] acc;
        acc = ({2'b00, prev} * 10'd3) + {2'b00, meas} + 10'd2;
        return acc[9:2];
    endfunction

endpackage

// File: rtl/vip_frame_timing.sv
// -----------------------------------------------------------------------------
// vip_frame_timing
// VIP frame timing tracker: vsync/href edge detection plus per-frame pixel and
// line counters with a line-length check.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_vsync/i_href/i_clken : VIP timing inputs
//   i_clear             : restart counters and error flag (frame start)
//   i_active            : counting enabled (frame in progress)
//   o_vs_rise/o_vs_fall : vsync edges, combinational from the 1-cycle delayed copy
//   o_vcnt              : completed lines in this frame (saturating)
//   o_err_acc           : sticky flag, some line had the wrong pixel count
// -----------------------------------------------------------------------------
module vip_frame_timing #(
    parameter logic [10:0] IMG_HDISP = 11'd1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_vsync,
    input  logic        i_href,
    input  logic        i_clken,
    input  logic        i_clear,
    input  logic        i_active,
    output logic        o_vs_rise,
    output logic        o_vs_fall,
    output logic [10:0] o_vcnt,
    output logic        o_err_acc
);

    logic        r_vsync_d;
    logic        r_href_d;
    logic [10:0] r_hcnt;
    logic [10:0] r_vcnt;
    logic        r_err_acc;
    logic        w_href_fall;

    assign o_vs_rise   = i_vsync & ~r_vsync_d;
    assign o_vs_fall   = ~i_vsync & r_vsync_d;
    assign w_href_fall = ~i_href & r_href_d;
    assign o_vcnt      = r_vcnt;
    assign o_err_acc   = r_err_acc;

    // Delayed copies of vsync/href for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vsync_d <= 1'b0;
            r_href_d  <= 1'b0;
        end else begin
            r_vsync_d <= i_vsync;
            r_href_d  <= i_href;
        end
    end

    // Pixel/line counters and line-length check. A pixel on the href falling
    // cycle cannot exist (href is already low), so the two branches never clash.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hcnt    <= 11'd0;
            r_vcnt    <= 11'd0;
            r_err_acc <= 1'b0;
        end else if (i_clear) begin
            r_hcnt    <= 11'd0;
            r_vcnt    <= 11'd0;
            r_err_acc <= 1'b0;
        end else if (i_active) begin
            if (w_href_fall) begin
                if (r_hcnt != IMG_HDISP) begin
                    r_err_acc <= 1'b1;
                end else begin
                    r_err_acc <= r_err_acc;
                end
                if (r_vcnt != 11'd2047) begin
                    r_vcnt <= r_vcnt + 11'd1;
                end else begin
                    r_vcnt <= r_vcnt;
                end
                r_hcnt <= 11'd0;
            end else if (i_href && i_clken && (r_hcnt != 11'd2047)) begin
                r_hcnt <= r_hcnt + 11'd1;
            end else begin
                r_hcnt <= r_hcnt;
            end
        end else begin
            r_hcnt    <= r_hcnt;
            r_vcnt    <= r_vcnt;
            r_err_acc <= r_err_acc;
        end
    end

endmodule

// File: rtl/dehaze_atmos_ctrl.sv
// -----------------------------------------------------------------------------
// dehaze_atmos_ctrl
// Frame-level controller for the dehaze scene-radiance stage. Measures the
// per-frame maximum dark-channel value and commits it (clamped to ATMOS_MAX)
// as the atmospheric light at frame end, unless the frame was malformed or
// cfg_freeze is set. Also lower-clamps the transmission stream to T_MIN.
// Optional build macro: ATMOS_IIR_EN -- smooth the committed value with
// (3*old + new + 2) >> 2 instead of taking the new measurement directly.
// Ports:
//   clk, rst                 : pixel clock, synchronous active-high reset
//   per_frame_vsync/href/clken, per_dark_channel, per_transmission : inputs
//   cfg_freeze               : hold atmospheric_light
//   post_frame_vsync/href/clken, post_transmission : 1-clock delayed stream
//   atmospheric_light        : committed atmospheric light
//   frame_done               : 1-cycle pulse when a frame is committed
//   frame_err                : result of the last frame check
//   frame_cnt                : completed frames, wraps
// -----------------------------------------------------------------------------
module dehaze_atmos_ctrl
    import dehaze_pkg::*;
#(
    parameter logic [10:0]      IMG_HDISP     = IMG_HDISP_DEF,
    parameter logic [10:0]      IMG_VDISP     = IMG_VDISP_DEF,
    parameter logic [PIX_W-1:0] T_MIN         = T_MIN_DEF,
    parameter logic [PIX_W-1:0] ATMOS_DEFAULT = ATMOS_DEFAULT_DEF,
    parameter logic [PIX_W-1:0] ATMOS_MAX     = ATMOS_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic [PIX_W-1:0] per_dark_channel,
    input  logic [PIX_W-1:0] per_transmission,
    input  logic             cfg_freeze,
    output logic             post_frame_vsync,
    output logic             post_frame_href,
    output logic             post_frame_clken,
    output logic [PIX_W-1:0] post_transmission,
    output logic [PIX_W-1:0] atmospheric_light,
    output logic             frame_done,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);

    state_e           r_state;
    state_e           w_state_next;
    logic             w_clear;
    logic             w_commit;
    logic             w_active;
    logic             w_vs_rise;
    logic             w_vs_fall;
    logic [10:0]      w_vcnt;
    logic             w_err_acc;
    logic             w_frame_err;
    logic [PIX_W-1:0] w_meas;
    logic [PIX_W-1:0] w_atmos_next;

    logic [PIX_W-1:0] r_dc_max;
    logic [PIX_W-1:0] r_atmos;
    logic             r_frame_done;
    logic             r_frame_err;
    logic [15:0]      r_frame_cnt;
    logic             r_post_vsync;
    logic             r_post_href;
    logic             r_post_clken;
    logic [PIX_W-1:0] r_post_trans;

    assign w_active = (r_state == ACTIVE);
    assign w_commit = (r_state == COMMIT);

    vip_frame_timing #(
        .IMG_HDISP (IMG_HDISP)
    ) u_timing (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_vsync   (per_frame_vsync),
        .i_href    (per_frame_href),
        .i_clken   (per_frame_clken),
        .i_clear   (w_clear),
        .i_active  (w_active),
        .o_vs_rise (w_vs_rise),
        .o_vs_fall (w_vs_fall),
        .o_vcnt    (w_vcnt),
        .o_err_acc (w_err_acc)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state. SYNC skips any frame already running at reset release.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        case (r_state)
            SYNC: begin
                if (!per_frame_vsync) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = SYNC;
                end
            end
            IDLE: begin
                if (w_vs_rise) begin
                    w_clear      = 1'b1;
                    w_state_next = ACTIVE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            ACTIVE: begin
                if (w_vs_fall) begin
                    w_state_next = COMMIT;
                end else begin
                    w_state_next = ACTIVE;
                end
            end
            COMMIT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = SYNC;
            end
        endcase
    end

    // Per-frame maximum dark-channel value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dc_max <= 8'd0;
        end else if (w_clear) begin
            r_dc_max <= 8'd0;
        end else if (w_active && per_frame_href && per_frame_clken &&
                     (per_dark_channel > r_dc_max)) begin
            r_dc_max <= per_dark_channel;
        end else begin
            r_dc_max <= r_dc_max;
        end
    end

    // vcnt already includes a line closed together with the vsync fall.
    assign w_frame_err = w_err_acc | (w_vcnt != IMG_VDISP);
    assign w_meas      = min_u8(r_dc_max, ATMOS_MAX);

`ifdef ATMOS_IIR_EN
    assign w_atmos_next = atmos_iir_step(r_atmos, w_meas);
`else
    assign w_atmos_next = w_meas;
`endif

    // Frame commit: status, frame counter and atmospheric-light update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_atmos      <= ATMOS_DEFAULT;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_cnt  <= 16'd0;
        end else begin
            r_frame_done <= w_commit;
            if (w_commit) begin
                r_frame_err <= w_frame_err;
                r_frame_cnt <= r_frame_cnt + 16'd1;
                if (!w_frame_err && !cfg_freeze) begin
                    r_atmos <= w_atmos_next;
                end else begin
                    r_atmos <= r_atmos;
                end
            end else begin
                r_frame_err <= r_frame_err;
                r_frame_cnt <= r_frame_cnt;
                r_atmos     <= r_atmos;
            end
        end
    end

    // Transmission clamp and timing delay; independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_post_vsync <= 1'b0;
            r_post_href  <= 1'b0;
            r_post_clken <= 1'b0;
            r_post_trans <= 8'd0;
        end else begin
            r_post_vsync <= per_frame_vsync;
            r_post_href  <= per_frame_href;
            r_post_clken <= per_frame_clken;
            r_post_trans <= (per_transmission < T_MIN) ? T_MIN : per_transmission;
        end
    end

    assign post_frame_vsync  = r_post_vsync;
    assign post_frame_href   = r_post_href;
    assign post_frame_clken  = r_post_clken;
    assign post_transmission = r_post_trans;
    assign atmospheric_light = r_atmos;
    assign frame_done        = r_frame_done;
    assign frame_err         = r_frame_err;
    assign frame_cnt         = r_frame_cnt;

endmodule

// File: tb/tb_dehaze_atmos_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dehaze_atmos_ctrl
// Directed bench for dehaze_atmos_ctrl with a 4x3 frame geometry (default
// build, direct commit). Inputs change 1 time unit after the rising edge;
// outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_dehaze_atmos_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic        href;
    logic        clken;
    logic [7:0]  dark;
    logic [7:0]  trans;
    logic        freeze;
    logic        post_vsync;
    logic        post_href;
    logic        post_clken;
    logic [7:0]  post_trans;
    logic [7:0]  atmos;
    logic        done;
    logic        err;
    logic [15:0] cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dehaze_atmos_ctrl #(
        .IMG_HDISP     (11'd4),
        .IMG_VDISP     (11'd3),
        .T_MIN         (8'd26),
        .ATMOS_DEFAULT (8'd220),
        .ATMOS_MAX     (8'd240)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .per_frame_vsync   (vsync),
        .per_frame_href    (href),
        .per_frame_clken   (clken),
        .per_dark_channel  (dark),
        .per_transmission  (trans),
        .cfg_freeze        (freeze),
        .post_frame_vsync  (post_vsync),
        .post_frame_href   (post_href),
        .post_frame_clken  (post_clken),
        .post_transmission (post_trans),
        .atmospheric_light (atmos),
        .frame_done        (done),
        .frame_err         (err),
        .frame_cnt         (cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One line of npix pixels; optional peak on pixel 1. The blanking after
    // the line carries clken=1 with a large value that must be ignored.
    task automatic drive_line(input int npix, input logic [7:0] peak, input bit put_peak);
        for (int p = 0; p < npix; p++) begin
            href  = 1'b1;
            clken = 1'b1;
            dark  = (put_peak && p == 1) ? peak : (8'd20 + 8'(p));
            tick();
        end
        href  = 1'b0;
        clken = 1'b1;
        dark  = 8'd255;
        tick();
        clken = 1'b0;
        dark  = 8'd0;
        tick();
    endtask

    // Whole frame; returns with the commit results visible (done should be 1).
    task automatic run_frame(input int nlines, input int short_idx, input logic [7:0] peak);
        vsync = 1'b1;
        tick();
        tick();
        for (int l = 0; l < nlines; l++) begin
            drive_line((l == short_idx) ? 3 : 4, peak, l == 0);
        end
        vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_commit(input string tag, input logic [7:0] e_atmos,
                                input logic e_err, input logic [15:0] e_cnt);
        check_eq({tag, "_done"},  {31'd0, done},  32'd1);
        check_eq({tag, "_atmos"}, {24'd0, atmos}, {24'd0, e_atmos});
        check_eq({tag, "_err"},   {31'd0, err},   {31'd0, e_err});
        check_eq({tag, "_cnt"},   {16'd0, cnt},   {16'd0, e_cnt});
        tick();
        check_eq({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic seen;
        rst    = 1'b1;
        vsync  = 1'b0;
        href   = 1'b0;
        clken  = 1'b0;
        dark   = 8'd0;
        trans  = 8'd0;
        freeze = 1'b0;
        tick();
        tick();
        tick();

        // Reset state
        check_eq("rst_atmos", {24'd0, atmos}, 32'd220);
        check_eq("rst_done",  {31'd0, done},  32'd0);
        check_eq("rst_err",   {31'd0, err},   32'd0);
        check_eq("rst_cnt",   {16'd0, cnt},   32'd0);
        check_eq("rst_trans", {24'd0, post_trans}, 32'd0);
        check_eq("rst_pvs",   {31'd0, post_vsync}, 32'd0);

        rst   = 1'b0;
        trans = 8'd128;
        tick();
        tick();

        // Good frame, peak 200
        run_frame(3, -1, 8'd200);
        check_commit("good200", 8'd200, 1'b0, 16'd1);

        // Peak above ATMOS_MAX is clamped
        run_frame(3, -1, 8'd250);
        check_commit("clamp250", 8'd240, 1'b0, 16'd2);

        // Short second line -> error, light held
        run_frame(3, 1, 8'd100);
        check_commit("shortline", 8'd240, 1'b1, 16'd3);

        // Only two lines -> error, light held
        run_frame(2, -1, 8'd100);
        check_commit("twolines", 8'd240, 1'b1, 16'd4);

        // Good frame clears the error
        run_frame(3, -1, 8'd210);
        check_commit("good210", 8'd210, 1'b0, 16'd5);

        // Transmission clamp and stream delay (outside a frame)
        trans = 8'd10;
        href  = 1'b1;
        clken = 1'b1;
        tick();
        check_eq("tr_10",    {24'd0, post_trans}, 32'd26);
        check_eq("tr_href1", {31'd0, post_href},  32'd1);
        check_eq("tr_clk1",  {31'd0, post_clken}, 32'd1);
        check_eq("tr_vs0",   {31'd0, post_vsync}, 32'd0);
        trans = 8'd100;
        href  = 1'b0;
        tick();
        check_eq("tr_100",   {24'd0, post_trans}, 32'd100);
        check_eq("tr_href0", {31'd0, post_href},  32'd0);
        trans = 8'd25;
        clken = 1'b0;
        tick();
        check_eq("tr_25",    {24'd0, post_trans}, 32'd26);
        check_eq("tr_clk0",  {31'd0, post_clken}, 32'd0);
        trans = 8'd26;
        vsync = 1'b1;
        tick();
        check_eq("tr_26",    {24'd0, post_trans}, 32'd26);
        check_eq("tr_vs1",   {31'd0, post_vsync}, 32'd1);
        vsync = 1'b0;
        trans = 8'd128;
        tick();
        tick();
        tick();

        // Frozen good frame -> done pulses, light held
        freeze = 1'b1;
        run_frame(3, -1, 8'd150);
        check_commit("freeze", 8'd210, 1'b0, 16'd7);
        freeze = 1'b0;

        // Reset mid-frame, released while vsync is high
        vsync = 1'b1;
        tick();
        drive_line(4, 8'd250, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        check_eq("midrst_atmos", {24'd0, atmos}, 32'd220);
        check_eq("midrst_cnt",   {16'd0, cnt},   32'd0);
        rst = 1'b0;
        drive_line(4, 8'd30, 1'b1);
        drive_line(4, 8'd30, 1'b1);
        vsync = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | done;
        end
        check_eq("partial_no_done", {31'd0, seen}, 32'd0);
        run_frame(3, -1, 8'd205);
        check_commit("after_rst", 8'd205, 1'b0, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
